plaintext_block_fifo: RTL and testbench
=======================================

PLAINTEXT_BLOCK_FIFO -- requirements
Module: plaintext_block_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of 128-bit block entries; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port HCLK, input, 1, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port HRESETn, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port pt_wen, input, 1, plaintext word write strobe from the AHB write slave.
REQ-005 The block SHALL have port pt_index, input, 2, word position of pt_word within the 128-bit block (0 = bits [31:0] ... 3 = bits [127:96]).
REQ-006 The block SHALL have port pt_word, input, 32, plaintext data word.
REQ-007 The block SHALL have port fifo_full, output, 1, high when no block entry is free; returned to the write slave.
REQ-008 The block SHALL have port blk_data, output, 128, head-of-FIFO plaintext block to the cipher core.
REQ-009 The block SHALL have port blk_valid, output, 1, blk_data holds a valid block.
REQ-010 The block SHALL have port blk_ready, input, 1, cipher core accepts the head block this cycle.
REQ-011 The block SHALL have port fifo_count, output, 4, number of stored complete blocks (0..DEPTH).
REQ-012 The block SHALL have port order_error, output, 1, one-cycle pulse on an out-of-sequence word.
REQ-013 The block SHALL have port overflow_error, output, 1, one-cycle pulse on a block completion dropped because the FIFO is full.

Function
REQ-014 Assembly: 128-bit assembly register plus 2-bit expected-index counter exp_idx; a write is pt_wen=1 sampled on a rising HCLK edge.
REQ-015 A write with pt_index==exp_idx SHALL store pt_word into the addressed 32-bit lane and advance exp_idx (3 wraps to 0).
REQ-016 A write with pt_index!=exp_idx and pt_index==0 SHALL discard the partial block, store lane 0, set exp_idx=1, and pulse order_error.
REQ-017 A write with pt_index!=exp_idx and pt_index!=0 SHALL discard the partial block, set exp_idx=0, store nothing, and pulse order_error.
REQ-018 Push: an in-order lane-3 write SHALL push {pt_word, lanes 2..0} into the FIFO tail in that same edge when fifo_full==0.
REQ-019 An in-order lane-3 write while fifo_full==1 SHALL drop the block, pulse overflow_error, and reset exp_idx to 0; FIFO contents unchanged.
REQ-020 Pop: blk_valid = (fifo_count!=0); when blk_valid && blk_ready at an edge the head entry SHALL be removed.
REQ-021 Latency: a pushed block SHALL appear on blk_data/blk_valid the cycle after the lane-3 edge when FIFO was empty; zero-cycle bypass is not permitted.
REQ-022 Simultaneous push and pop (FIFO non-full) SHALL leave fifo_count unchanged; pointers both advance.
REQ-023 When full, push eligibility SHALL use fifo_full at the edge (pre-pop); a same-cycle pop does not rescue the push — overflow_error fires.
REQ-024 blk_ready while blk_valid==0 SHALL have no effect.
REQ-025 fifo_full = (fifo_count==DEPTH), combinational from registered count; read/write pointers wrap modulo DEPTH.
REQ-026 blk_data SHALL equal the head entry whenever blk_valid==1 and SHALL be stable until popped.
REQ-027 order_error and overflow_error SHALL be registered, high for exactly the cycle after the offending edge, and never both high.

Reset
REQ-028 HRESETn low SHALL immediately clear fifo_count to 0, pointers to 0, exp_idx to 0, assembly register to 0, blk_valid=0, fifo_full=0, order_error=0, overflow_error=0, blk_data=0.
REQ-029 Reset mid-block or mid-burst SHALL discard all partial and stored blocks; no pop or push completes on the releasing edge.

Verification
REQ-030 Write words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at indices 0..3 -> next cycle blk_valid=1, blk_data=0x44444444_33333333_22222222_11111111, fifo_count=1.
REQ-031 Indices 0,1,3 -> order_error pulse after the index-3 edge, fifo_count stays 0; then full 0..3 sequence -> one correct block.
REQ-032 Push 4 blocks with blk_ready=0 -> fifo_full=1, fifo_count=4; a 5th block -> overflow_error pulse, count stays 4, head unchanged.
REQ-033 FIFO full, blk_ready=1 on same edge as 5th lane-3 write -> overflow_error, count=3 afterwards; FIFO order preserved.
REQ-034 Count=2, blk_ready=1 on same edge as lane-3 push -> count stays 2, next head is the older second block.
REQ-035 Assert HRESETn=0 after lanes 0,1 with 3 blocks stored -> outputs zero immediately; after release, new 0..3 sequence yields a single block.

Source files
------------

// File: rtl/plaintext_block_fifo.sv
// Assembles 32-bit plaintext words into 128-bit blocks and queues complete
// blocks in a DEPTH-entry FIFO for the cipher core.
module plaintext_block_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         pt_wen,
  input  logic [1:0]   pt_index,
  input  logic [31:0]  pt_word,
  output logic         fifo_full,
  output logic [127:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [3:0]   fifo_count,
  output logic         order_error,
  output logic         overflow_error
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  logic [1:0]         exp_idx;
  logic [1:0]         exp_idx_next;
  // Lanes 0..2 only; lane 3 goes straight into the FIFO with the push.
  logic [2:0][31:0]   asm_q;
  logic [2:0][31:0]   asm_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [127:0]       mem [DEPTH];

  logic in_order;
  logic lane3_wr;
  logic push;
  logic pop;
  logic ord_err_next;
  logic ovf_err_next;

  assign fifo_count = count_q;
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign blk_valid  = (count_q != '0);
  assign blk_data   = blk_valid ? mem[rd_ptr] : '0;

  assign in_order     = (pt_index == exp_idx);
  assign lane3_wr     = pt_wen && in_order && (pt_index == 2'd3);
  assign push         = lane3_wr && !fifo_full;
  assign ovf_err_next = lane3_wr && fifo_full;
  assign pop          = blk_valid && blk_ready;
  assign ord_err_next = pt_wen && !in_order;

  // Assembly register and expected-index sequencing.
  always_comb begin
    exp_idx_next = exp_idx;
    asm_next     = asm_q;
    if (pt_wen) begin
      if (in_order) begin
        exp_idx_next = exp_idx + 2'd1;
        case (pt_index)
          2'd0:    asm_next[0] = pt_word;
          2'd1:    asm_next[1] = pt_word;
          2'd2:    asm_next[2] = pt_word;
          default: ;
        endcase
      end else if (pt_index == 2'd0) begin
        asm_next     = '0;
        asm_next[0]  = pt_word;
        exp_idx_next = 2'd1;
      end else begin
        asm_next     = '0;
        exp_idx_next = 2'd0;
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      exp_idx        <= '0;
      asm_q          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      order_error    <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      exp_idx        <= exp_idx_next;
      asm_q          <= asm_next;
      order_error    <= ord_err_next;
      overflow_error <= ovf_err_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= {pt_word, asm_q[2], asm_q[1], asm_q[0]};
  end

endmodule

// File: tb/tb_plaintext_block_fifo.sv
// Scoreboard bench for plaintext_block_fifo: a reference model predicts
// blocks, error pulses and occupancy for every driven cycle.
module tb_plaintext_block_fifo;

  localparam int unsigned DEPTH = 4;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic         pt_wen = 1'b0;
  logic [1:0]   pt_index = '0;
  logic [31:0]  pt_word = '0;
  logic         fifo_full;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [3:0]   fifo_count;
  logic         order_error;
  logic         overflow_error;

  int n_checks = 0;
  int n_fail = 0;

  logic [1:0]   m_exp = '0;
  logic [31:0]  m_asm [3];
  logic [127:0] q [$];

  plaintext_block_fifo #(.DEPTH(DEPTH)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .pt_wen(pt_wen),
    .pt_index(pt_index),
    .pt_word(pt_word),
    .fifo_full(fifo_full),
    .blk_data(blk_data),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .fifo_count(fifo_count),
    .order_error(order_error),
    .overflow_error(overflow_error)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_exp = '0;
    for (int i = 0; i < 3; i++) m_asm[i] = '0;
  endtask

  // One clock of stimulus; model predicts the post-edge state.
  task automatic cycle(input logic wen, input logic [1:0] idx, input logic [31:0] word,
                       input logic rdy);
    logic pre_full;
    logic exp_ord;
    logic exp_ovf;
    @(negedge HCLK);
    pre_full = (q.size() == DEPTH);
    exp_ord = 1'b0;
    exp_ovf = 1'b0;
    if (rdy && q.size() != 0) begin
      check("head_at_pop", blk_data, q[0]);
      void'(q.pop_front());
    end
    if (wen) begin
      if (idx == m_exp) begin
        if (idx == 2'd3) begin
          if (!pre_full) q.push_back({word, m_asm[2], m_asm[1], m_asm[0]});
          else exp_ovf = 1'b1;
        end else begin
          m_asm[idx] = word;
        end
        m_exp = m_exp + 2'd1;
      end else begin
        exp_ord = 1'b1;
        for (int i = 0; i < 3; i++) m_asm[i] = '0;
        if (idx == 2'd0) begin
          m_asm[0] = word;
          m_exp = 2'd1;
        end else begin
          m_exp = 2'd0;
        end
      end
    end
    pt_wen = wen;
    pt_index = idx;
    pt_word = word;
    blk_ready = rdy;
    @(posedge HCLK);
    #1;
    pt_wen = 1'b0;
    blk_ready = 1'b0;
    check("order_error", order_error, exp_ord);
    check("overflow_error", overflow_error, exp_ovf);
    check("fifo_count", fifo_count, q.size());
    check("blk_valid", blk_valid, q.size() != 0);
    check("fifo_full", fifo_full, q.size() == DEPTH);
    if (q.size() != 0) check("blk_data", blk_data, q[0]);
    else check("blk_data_idle", blk_data, '0);
  endtask

  task automatic write_block(input logic [31:0] base, input logic rdy_last);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 2'(i), base + 32'(i), (i == 3) ? rdy_last : 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 2'd0, 32'h0, 1'b1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, blk_valid, 1'b0);
    check({tag, "_count"}, fifo_count, 4'd0);
    check({tag, "_full"}, fifo_full, 1'b0);
    check({tag, "_oerr"}, order_error, 1'b0);
    check({tag, "_ovf"}, overflow_error, 1'b0);
    check({tag, "_data"}, blk_data, '0);
  endtask

  initial begin
    model_clear();
    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    cycle(1'b0, 2'd0, 32'h0, 1'b0);

    // Basic assembly with fixed words
    cycle(1'b1, 2'd0, 32'h11111111, 1'b0);
    cycle(1'b1, 2'd1, 32'h22222222, 1'b0);
    cycle(1'b1, 2'd2, 32'h33333333, 1'b0);
    cycle(1'b1, 2'd3, 32'h44444444, 1'b0);
    check("basic_block", blk_data, 128'h44444444_33333333_22222222_11111111);
    check("basic_count", fifo_count, 4'd1);
    pop_one();

    // Skipped index: 0,1,3 then a clean block
    cycle(1'b1, 2'd0, 32'hA0, 1'b0);
    cycle(1'b1, 2'd1, 32'hA1, 1'b0);
    cycle(1'b1, 2'd3, 32'hA3, 1'b0);
    check("skip_oerr", order_error, 1'b1);
    check("skip_count", fifo_count, 4'd0);
    write_block(32'hB000_0000, 1'b0);
    pop_one();

    // Restart at index 0 mid-block
    cycle(1'b1, 2'd0, 32'hC0, 1'b0);
    cycle(1'b1, 2'd1, 32'hC1, 1'b0);
    cycle(1'b1, 2'd0, 32'hD0, 1'b0);
    check("restart_oerr", order_error, 1'b1);
    cycle(1'b1, 2'd1, 32'hD1, 1'b0);
    cycle(1'b1, 2'd2, 32'hD2, 1'b0);
    cycle(1'b1, 2'd3, 32'hD3, 1'b0);
    pop_one();

    // Ready while empty has no effect
    pop_one();
    pop_one();

    // Fill to full, then overflow
    for (int b = 0; b < 4; b++) write_block(32'h1000_0000 * 32'(b + 1), 1'b0);
    check("full_flag", fifo_full, 1'b1);
    check("full_count", fifo_count, 4'd4);
    write_block(32'h5555_0000, 1'b0);
    check("ovf_count", fifo_count, 4'd4);

    // Overflow with same-edge pop: push still dropped
    write_block(32'h6666_0000, 1'b1);
    check("ovf_pop_count", fifo_count, 4'd3);
    repeat (3) pop_one();

    // Simultaneous push and pop at count 2
    write_block(32'h7000_0000, 1'b0);
    write_block(32'h7100_0000, 1'b0);
    write_block(32'h7200_0000, 1'b1);
    check("pushpop_count", fifo_count, 4'd2);
    repeat (2) pop_one();

    // Reset mid-block with stored blocks
    for (int b = 0; b < 3; b++) write_block(32'h8000_0000 + 32'(b << 8), 1'b0);
    cycle(1'b1, 2'd0, 32'h90, 1'b0);
    cycle(1'b1, 2'd1, 32'h91, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_clear();
    @(negedge HCLK);
    HRESETn = 1'b1;
    cycle(1'b0, 2'd0, 32'h0, 1'b0);
    write_block(32'hE000_0000, 1'b0);
    check("post_reset_count", fifo_count, 4'd1);
    pop_one();

    // Random traffic, mostly in order
    for (int n = 0; n < 400; n++) begin
      logic [1:0] idx;
      idx = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : m_exp;
      cycle($urandom_range(0, 3) != 0, idx, $urandom, $urandom_range(0, 2) == 0);
    end
    while (q.size() != 0) pop_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
